uart_rx_deserializer: RTL and testbench

Receive front end for the Arty UART path. It takes the raw serial line from the USB-UART bridge pin and recovers 8N1 frames using an oversampled bit clock. It delivers each byte to the downstream UART controller over a valid/ready handshake. Framing errors and overruns are flagged so the controller never sees corrupt or silently dropped data.

---
 rtl/uart_rx_deserializer.sv | 182 ++++++++++++++++++
 tb/tb_uart_rx_deserializer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deserializer.sv
// 8N1 UART receiver: oversampled start/data/stop recovery delivering bytes over valid/ready.
// Framing errors and overruns are reported as single-cycle pulses.
module uart_rx_deserializer #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD        = 115200,
    parameter int OVERSAMPLE  = 16,
    parameter int DATA_BITS   = 8
) (
    input  logic                 CLK100MHZ,
    input  logic                 ck_rst,
    input  logic                 uart_rxd_out,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int DIV    = (CLK_FREQ_HZ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
    localparam int TICK_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SAMP_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIV - 1);
    localparam logic [SAMP_W-1:0] SAMP_MID  = SAMP_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    generate
        if (DIV < 1) begin : g_div_check
            $error("uart_rx_deserializer: clock too slow for BAUD*OVERSAMPLE (DIV < 1)");
        end
        if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_os_check
            $error("uart_rx_deserializer: OVERSAMPLE must be even and >= 8");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_e;

    state_e                state_q, state_d;
    logic                  sync1_q, sync2_q, sync3_q;
    logic [1:0]            settle_q, settle_d;
    logic                  armed_q, armed_d;
    logic [TICK_W-1:0]     tick_cnt_q, tick_cnt_d;
    logic [SAMP_W-1:0]     samp_cnt_q, samp_cnt_d;
    logic [BIT_W-1:0]      bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic                  byte_done_q, byte_done_d;
    logic [DATA_BITS-1:0]  rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  frame_err_q, frame_err_d;
    logic                  overrun_q, overrun_d;

    logic rxs;
    logic fall;
    logic tick;
    logic mid_pt;
    logic bit_pt;

    assign rxs    = sync2_q;
    // A start edge only counts once the line has been seen high after reset,
    // so a line held low through reset release cannot fake a start bit.
    assign fall   = armed_q & sync3_q & ~sync2_q;
    assign tick   = (tick_cnt_q == TICK_LAST);
    assign mid_pt = tick && (samp_cnt_q == SAMP_MID);
    assign bit_pt = tick && (samp_cnt_q == SAMP_LAST);

    // NOTE: sequential state uses non-blocking assignments only; all next-state math lives in always_comb.
    always_ff @(posedge CLK100MHZ or negedge ck_rst) begin
        if (!ck_rst) begin
            state_q     <= S_IDLE;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            sync3_q     <= 1'b1;
            settle_q    <= '0;
            armed_q     <= 1'b0;
            tick_cnt_q  <= '0;
            samp_cnt_q  <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            byte_done_q <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= uart_rxd_out;
            sync2_q     <= sync1_q;
            sync3_q     <= sync2_q;
            settle_q    <= settle_d;
            armed_q     <= armed_d;
            tick_cnt_q  <= tick_cnt_d;
            samp_cnt_q  <= samp_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            byte_done_q <= byte_done_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:      if (fall)   state_d = S_START;
            S_START:     if (mid_pt) state_d = rxs ? S_IDLE : S_DATA;
            S_DATA:      if (bit_pt && bit_idx_q == BIT_LAST) state_d = S_STOP;
            S_STOP:      if (bit_pt) state_d = rxs ? S_IDLE : S_WAIT_HIGH;
            S_WAIT_HIGH: if (rxs)    state_d = S_IDLE;
            default:                 state_d = S_IDLE;
        endcase
    end

    // NOTE: every signal gets a default before any branch so no latch can be inferred.
    always_comb begin
        settle_d    = {settle_q[0], 1'b1};
        armed_d     = armed_q | (settle_q[1] & rxs);
        tick_cnt_d  = tick_cnt_q;
        samp_cnt_d  = samp_cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        byte_done_d = 1'b0;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;

        if (state_q == S_IDLE) begin
            tick_cnt_d = '0;
            samp_cnt_d = '0;
            bit_idx_d  = '0;
        end else begin
            tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
            if (tick) begin
                samp_cnt_d = (samp_cnt_q == SAMP_LAST) ? '0 : samp_cnt_q + SAMP_W'(1);
            end
        end

        unique case (state_q)
            S_START: if (mid_pt) samp_cnt_d = '0;
            S_DATA: begin
                if (bit_pt) begin
                    shift_d   = DATA_BITS'({rxs, shift_q} >> 1);
                    bit_idx_d = bit_idx_q + BIT_W'(1);
                end
            end
            S_STOP: begin
                if (bit_pt) begin
                    byte_done_d = rxs;
                    frame_err_d = ~rxs;
                end
            end
            default: ;
        endcase

        // Delivery one cycle after the mid-stop sample; a pending unconsumed byte wins.
        if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
        if (byte_done_q) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed + randomized bench for uart_rx_deserializer at 16 clocks per bit.
// Expected bytes and flag counts come from frame-level rules applied to what the bench sends.
module tb_uart_rx_deserializer;

    localparam int BIT_CYC = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       line;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;

    int total = 0;
    int bad   = 0;

    uart_rx_deserializer #(
        .CLK_FREQ_HZ(1_600_000),
        .BAUD       (100_000),
        .OVERSAMPLE (16),
        .DATA_BITS  (8)
    ) dut (
        .CLK100MHZ   (clk),
        .ck_rst      (rst_n),
        .uart_rxd_out(line),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .frame_err   (frame_err),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    // Passive monitor sampled mid-cycle: counts events and records accepted bytes.
    int         n_vcyc  = 0;
    int         n_vfall = 0;
    int         n_stab  = 0;
    int         n_fe    = 0;
    int         n_ov    = 0;
    int         n_both  = 0;
    int         n_got   = 0;
    logic [7:0] got [0:63];
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    always @(negedge clk) begin
        if (rx_valid) n_vcyc++;
        if (prev_valid && !rx_valid) n_vfall++;
        if (prev_valid && !prev_ready && rx_valid && rx_data !== prev_data) n_stab++;
        if (frame_err) n_fe++;
        if (overrun) n_ov++;
        if (frame_err && overrun) n_both++;
        if (rx_valid && rx_ready) begin
            if (n_got < 64) got[n_got] = rx_data;
            n_got++;
        end
        prev_valid = rx_valid;
        prev_ready = rx_ready;
        prev_data  = rx_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        line = 1'b1;
        repeat (n) step();
    endtask

    // Drives one 8N1 frame; the line is left at the stop-bit level.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            line = bits[i];
            repeat (BIT_CYC) step();
        end
    endtask

    logic [7:0] exp_q[$];
    int         rd = 0;

    task automatic expect_bytes(input string tag);
        logic [7:0] e;
        logic [7:0] v;
        check({tag, "_count"}, n_got - rd, exp_q.size());
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            v = (rd < n_got && rd < 64) ? got[rd] : 8'hxx;
            check({tag, "_byte"}, {24'h0, v}, {24'h0, e});
            rd++;
        end
        rd = n_got;
    endtask

    initial begin
        int         lat;
        int         fe0, ov0, vc0, vf0, st0, fe_exp;
        logic [7:0] b;

        rst_n    = 1'b0;
        line     = 1'b1;
        rx_ready = 1'b0;
        fe_exp   = 0;
        #1;
        check("rst_valid", rx_valid, 1'b0);
        check("rst_data", rx_data, 8'h00);
        check("rst_ferr", frame_err, 1'b0);
        check("rst_ovr", overrun, 1'b0);
        repeat (3) step();
        rst_n = 1'b1;
        idle(10);

        // 1: single 0xA5 with latency, then random bytes with random gaps
        rx_ready = 1'b1;
        vc0 = n_vcyc; fe0 = n_fe; ov0 = n_ov;
        lat = 400;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                for (int i = 1; i <= 400; i++) begin
                    @(posedge clk);
                    #1;
                    if (rx_valid) begin
                        lat = i;
                        break;
                    end
                end
            end
        join
        exp_q.push_back(8'hA5);
        idle(20);
        total++;
        assert (lat >= 155 && lat <= 157) else begin
            bad++;
            $error("FAIL t1_latency: observed=%0d expected=155..157", lat);
        end
        check("t1_valid_cycles", n_vcyc - vc0, 1);
        expect_bytes("t1");
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom);
            send_frame(b, 1'b1);
            exp_q.push_back(b);
            idle($urandom_range(0, 6));
        end
        idle(20);
        expect_bytes("t1_rand");
        check("t1_ferr", n_fe - fe0, 0);
        check("t1_ovr", n_ov - ov0, 0);

        // 2: short glitch is ignored, following frame received
        vc0 = n_vcyc; fe0 = n_fe;
        line = 1'b0;
        repeat (4) step();
        idle(40);
        check("t2_glitch_valid", n_vcyc - vc0, 0);
        check("t2_glitch_ferr", n_fe - fe0, 0);
        send_frame(8'h3C, 1'b1);
        exp_q.push_back(8'h3C);
        idle(20);
        expect_bytes("t2");

        // 3: low stop bit followed by a break -> one frame_err, nothing delivered
        vc0 = n_vcyc; fe0 = n_fe;
        send_frame(8'h55, 1'b0);
        fe_exp++;
        repeat (40) step();
        idle(30);
        check("t3_ferr_count", n_fe - fe0, fe_exp);
        check("t3_valid", n_vcyc - vc0, 0);
        expect_bytes("t3_none");
        send_frame(8'h0F, 1'b1);
        exp_q.push_back(8'h0F);
        idle(20);
        expect_bytes("t3");

        // 4: consumer stalled across two back-to-back frames -> overrun, first byte kept
        rx_ready = 1'b0;
        ov0 = n_ov; st0 = n_stab; fe0 = n_fe;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        idle(10);
        check("t4_valid", rx_valid, 1'b1);
        check("t4_data", rx_data, 8'h11);
        check("t4_ovr_count", n_ov - ov0, 1);
        check("t4_stable", n_stab - st0, 0);
        check("t4_ferr", n_fe - fe0, 0);
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
        step();
        check("t4_drained", rx_valid, 1'b0);
        exp_q.push_back(8'h11);
        expect_bytes("t4");

        // 5: ready only on the delivery cycle of the second byte
        ov0 = n_ov; vf0 = n_vfall;
        fork
            begin
                send_frame(8'h80, 1'b1);
                send_frame(8'h01, 1'b1);
            end
            begin
                repeat (BIT_CYC * 10 + 155) step();
                rx_ready = 1'b1;
                step();
                rx_ready = 1'b0;
            end
        join
        idle(10);
        check("t5_ovr", n_ov - ov0, 0);
        check("t5_no_drop", n_vfall - vf0, 0);
        check("t5_valid", rx_valid, 1'b1);
        check("t5_data", rx_data, 8'h01);
        exp_q.push_back(8'h80);
        expect_bytes("t5_first");
        rx_ready = 1'b1;
        step();
        step();
        check("t5_drained", rx_valid, 1'b0);
        exp_q.push_back(8'h01);
        expect_bytes("t5_second");

        // 6: reset in the middle of 0xFF's data bits
        vc0 = n_vcyc; fe0 = n_fe; ov0 = n_ov;
        fork
            send_frame(8'hFF, 1'b1);
            begin
                repeat (BIT_CYC * 4 + 5) step();
                rst_n = 1'b0;
                #1;
                check("t6_rst_data", rx_data, 8'h00);
                check("t6_rst_valid", rx_valid, 1'b0);
                check("t6_rst_flags", {frame_err, overrun}, 2'b00);
                repeat (2) step();
                rst_n = 1'b1;
            end
        join
        idle(30);
        check("t6_no_valid", n_vcyc - vc0, 0);
        check("t6_no_ferr", n_fe - fe0, 0);
        check("t6_no_ovr", n_ov - ov0, 0);
        expect_bytes("t6_none");
        send_frame(8'h5A, 1'b1);
        exp_q.push_back(8'h5A);
        idle(20);
        expect_bytes("t6");

        // 7: line held low through reset release must not start a frame
        vc0 = n_vcyc; fe0 = n_fe;
        rst_n = 1'b0;
        line  = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (200) step();
        idle(30);
        check("t7_no_valid", n_vcyc - vc0, 0);
        check("t7_no_ferr", n_fe - fe0, 0);
        b = 8'($urandom);
        send_frame(b, 1'b1);
        exp_q.push_back(b);
        idle(20);
        expect_bytes("t7");

        check("never_both_flags", n_both, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
